// File: rtl/dcache_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_axi_pkg
// Brief    : AXI encodings and W FIFO entry sizing shared by the dcache bridge.
// Revision : 1.0
// ============================================================================
package dcache_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // One FIFO entry is {last, strb, data}.
    function automatic int wfifo_width(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_axi_wfifo.sv
`default_nettype none
// ============================================================================
// Module   : dcache_axi_wfifo
// Brief    : Synchronous FIFO holding W beats; push is honoured when full if a
//            pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module dcache_axi_wfifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Pointers are PTR_W wide, so power-of-two depth wraps for free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dcache_axi_bridge
// Brief    : dcache single-channel request port to AXI4 master, with registered
//            AW/AR, W FIFO and outstanding limits. Optional error capture is
//            enabled by defining DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN.
// Revision : 1.0
// ============================================================================
module dcache_axi_bridge
    import dcache_axi_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int WBUF_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int STRB_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
    output logic              err_valid_o,
    output logic [1:0]        err_resp_o,
    output logic [ID_W-1:0]   err_id_o,
    input  logic              err_clear_i,
`endif
    input  logic              inport_valid_i,
    input  logic              inport_write_i,
    input  logic [ADDR_W-1:0] inport_addr_i,
    input  logic [ID_W-1:0]   inport_id_i,
    input  logic [7:0]        inport_len_i,
    input  logic [1:0]        inport_burst_i,
    input  logic [DATA_W-1:0] inport_wdata_i,
    input  logic [STRB_W-1:0] inport_wstrb_i,
    output logic              inport_accept_o,
    output logic              inport_bvalid_o,
    output logic [1:0]        inport_bresp_o,
    output logic [ID_W-1:0]   inport_bid_o,
    input  logic              inport_bready_i,
    output logic              inport_rvalid_o,
    output logic [DATA_W-1:0] inport_rdata_o,
    output logic [1:0]        inport_rresp_o,
    output logic [ID_W-1:0]   inport_rid_o,
    output logic              inport_rlast_o,
    input  logic              inport_rready_i,
    output logic              outport_awvalid_o,
    output logic [ADDR_W-1:0] outport_awaddr_o,
    output logic [ID_W-1:0]   outport_awid_o,
    output logic [7:0]        outport_awlen_o,
    output logic [1:0]        outport_awburst_o,
    input  logic              outport_awready_i,
    output logic              outport_wvalid_o,
    output logic [DATA_W-1:0] outport_wdata_o,
    output logic [STRB_W-1:0] outport_wstrb_o,
    output logic              outport_wlast_o,
    input  logic              outport_wready_i,
    input  logic              outport_bvalid_i,
    input  logic [1:0]        outport_bresp_i,
    input  logic [ID_W-1:0]   outport_bid_i,
    output logic              outport_bready_o,
    output logic              outport_arvalid_o,
    output logic [ADDR_W-1:0] outport_araddr_o,
    output logic [ID_W-1:0]   outport_arid_o,
    output logic [7:0]        outport_arlen_o,
    output logic [1:0]        outport_arburst_o,
    input  logic              outport_arready_i,
    input  logic              outport_rvalid_i,
    input  logic [DATA_W-1:0] outport_rdata_i,
    input  logic [1:0]        outport_rresp_i,
    input  logic [ID_W-1:0]   outport_rid_i,
    input  logic              outport_rlast_i,
    output logic              outport_rready_o
);
    localparam int FIFO_W = wfifo_width(DATA_W);
    localparam int WCNT_W = $clog2(WBUF_DEPTH) + 1;

    logic              r_bursting;
    logic [7:0]        r_beats_left;
    logic [3:0]        r_wr_out;
    logic [3:0]        r_rd_out;
    logic              w_wr_accept, w_rd_accept, w_last;
    logic              w_aw_hs, w_ar_hs, w_b_hs, w_r_hs, w_b_dec, w_r_dec;
    logic              w_full, w_empty;
    logic [FIFO_W-1:0] w_head;
    logic [WCNT_W-1:0] w_wfifo_count;

    assign w_aw_hs = outport_awvalid_o && outport_awready_i;
    assign w_ar_hs = outport_arvalid_o && outport_arready_i;
    assign w_b_hs  = outport_bvalid_i && inport_bready_i;
    assign w_r_hs  = outport_rvalid_i && inport_rready_i;
    assign w_b_dec = w_b_hs && (r_wr_out != 4'd0);
    assign w_r_dec = w_r_hs && outport_rlast_i && (r_rd_out != 4'd0);

    // A burst's later beats only need FIFO space; the first beat also needs
    // a free AW slot and outstanding headroom.
    always_comb begin
        w_wr_accept = 1'b0;
        w_rd_accept = 1'b0;
        if (inport_valid_i) begin
            if (inport_write_i) begin
                w_wr_accept = r_bursting ? !w_full
                            : (!outport_awvalid_o || outport_awready_i) && !w_full
                              && (r_wr_out < 4'(MAX_OUTSTANDING));
            end else begin
                w_rd_accept = !r_bursting && (!outport_arvalid_o || outport_arready_i)
                              && (r_rd_out < 4'(MAX_OUTSTANDING));
            end
        end
    end

    assign inport_accept_o = w_wr_accept || w_rd_accept;
    assign w_last = r_bursting ? (r_beats_left == 8'd1) : (inport_len_i == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bursting        <= 1'b0;
            r_beats_left      <= '0;
            r_wr_out          <= '0;
            r_rd_out          <= '0;
            outport_awvalid_o <= 1'b0;
            outport_awaddr_o  <= '0;
            outport_awid_o    <= '0;
            outport_awlen_o   <= '0;
            outport_awburst_o <= '0;
            outport_arvalid_o <= 1'b0;
            outport_araddr_o  <= '0;
            outport_arid_o    <= '0;
            outport_arlen_o   <= '0;
            outport_arburst_o <= '0;
        end else begin
            if (w_wr_accept) begin
                if (!r_bursting) begin
                    r_bursting   <= (inport_len_i != 8'd0);
                    r_beats_left <= inport_len_i;
                end else begin
                    r_beats_left <= r_beats_left - 8'd1;
                    if (r_beats_left == 8'd1) r_bursting <= 1'b0;
                end
            end
            if (w_wr_accept && !r_bursting) begin
                outport_awvalid_o <= 1'b1;
                outport_awaddr_o  <= inport_addr_i;
                outport_awid_o    <= inport_id_i;
                outport_awlen_o   <= inport_len_i;
                outport_awburst_o <= inport_burst_i;
            end else if (w_aw_hs) begin
                outport_awvalid_o <= 1'b0;
            end
            if (w_rd_accept) begin
                outport_arvalid_o <= 1'b1;
                outport_araddr_o  <= inport_addr_i;
                outport_arid_o    <= inport_id_i;
                outport_arlen_o   <= inport_len_i;
                outport_arburst_o <= inport_burst_i;
            end else if (w_ar_hs) begin
                outport_arvalid_o <= 1'b0;
            end
            if (w_aw_hs && !w_b_dec)      r_wr_out <= r_wr_out + 4'd1;
            else if (!w_aw_hs && w_b_dec) r_wr_out <= r_wr_out - 4'd1;
            if (w_ar_hs && !w_r_dec)      r_rd_out <= r_rd_out + 4'd1;
            else if (!w_ar_hs && w_r_dec) r_rd_out <= r_rd_out - 4'd1;
        end
    end

    dcache_axi_wfifo #(
        .WIDTH (FIFO_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_wr_accept),
        .push_data ({w_last, inport_wstrb_i, inport_wdata_i}),
        .pop       (outport_wvalid_o && outport_wready_i),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_wfifo_count)
    );

    assign outport_wvalid_o = !w_empty;
    assign {outport_wlast_o, outport_wstrb_o, outport_wdata_o} = w_head;

    assign inport_bvalid_o  = outport_bvalid_i;
    assign inport_bresp_o   = outport_bresp_i;
    assign inport_bid_o     = outport_bid_i;
    assign outport_bready_o = inport_bready_i;
    assign inport_rvalid_o  = outport_rvalid_i;
    assign inport_rdata_o   = outport_rdata_i;
    assign inport_rresp_o   = outport_rresp_i;
    assign inport_rid_o     = outport_rid_i;
    assign inport_rlast_o   = outport_rlast_i;
    assign outport_rready_o = inport_rready_i;

`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
    // Sticky first-error capture; B takes precedence over R in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || err_clear_i) begin
            err_valid_o <= 1'b0;
            err_resp_o  <= '0;
            err_id_o    <= '0;
        end else if (!err_valid_o) begin
            if (w_b_hs && outport_bresp_i != AXI_RESP_OKAY) begin
                err_valid_o <= 1'b1;
                err_resp_o  <= outport_bresp_i;
                err_id_o    <= outport_bid_i;
            end else if (w_r_hs && outport_rresp_i != AXI_RESP_OKAY) begin
                err_valid_o <= 1'b1;
                err_resp_o  <= outport_rresp_i;
                err_id_o    <= outport_rid_i;
            end
        end
    end
`else
    // Without capture, response codes are only forwarded upstream.
`endif

    a_wr_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_b_hs && r_wr_out == 4'd0));
    a_rd_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_r_hs && outport_rlast_i && r_rd_out == 4'd0));
    a_wfifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_wfifo_count <= WCNT_W'(WBUF_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_dcache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_axi_bridge
// Brief    : Directed self-checking bench for dcache_axi_bridge
//            (WBUF_DEPTH=4, MAX_OUTSTANDING=2).
// Revision : 1.0
// ============================================================================
module tb_dcache_axi_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inport_valid_i, inport_write_i;
    logic [31:0] inport_addr_i;
    logic [3:0]  inport_id_i;
    logic [7:0]  inport_len_i;
    logic [1:0]  inport_burst_i;
    logic [31:0] inport_wdata_i;
    logic [3:0]  inport_wstrb_i;
    logic        inport_accept_o;
    logic        inport_bvalid_o;
    logic [1:0]  inport_bresp_o;
    logic [3:0]  inport_bid_o;
    logic        inport_bready_i;
    logic        inport_rvalid_o;
    logic [31:0] inport_rdata_o;
    logic [1:0]  inport_rresp_o;
    logic [3:0]  inport_rid_o;
    logic        inport_rlast_o;
    logic        inport_rready_i;
    logic        outport_awvalid_o;
    logic [31:0] outport_awaddr_o;
    logic [3:0]  outport_awid_o;
    logic [7:0]  outport_awlen_o;
    logic [1:0]  outport_awburst_o;
    logic        outport_awready_i;
    logic        outport_wvalid_o;
    logic [31:0] outport_wdata_o;
    logic [3:0]  outport_wstrb_o;
    logic        outport_wlast_o;
    logic        outport_wready_i;
    logic        outport_bvalid_i;
    logic [1:0]  outport_bresp_i;
    logic [3:0]  outport_bid_i;
    logic        outport_bready_o;
    logic        outport_arvalid_o;
    logic [31:0] outport_araddr_o;
    logic [3:0]  outport_arid_o;
    logic [7:0]  outport_arlen_o;
    logic [1:0]  outport_arburst_o;
    logic        outport_arready_i;
    logic        outport_rvalid_i;
    logic [31:0] outport_rdata_i;
    logic [1:0]  outport_rresp_i;
    logic [3:0]  outport_rid_i;
    logic        outport_rlast_i;
    logic        outport_rready_o;
`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
    logic        err_valid_o;
    logic [1:0]  err_resp_o;
    logic [3:0]  err_id_o;
    logic        err_clear_i;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dcache_axi_bridge #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .WBUF_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
        .err_valid_o(err_valid_o), .err_resp_o(err_resp_o), .err_id_o(err_id_o),
        .err_clear_i(err_clear_i),
`endif
        .inport_valid_i(inport_valid_i), .inport_write_i(inport_write_i),
        .inport_addr_i(inport_addr_i), .inport_id_i(inport_id_i),
        .inport_len_i(inport_len_i), .inport_burst_i(inport_burst_i),
        .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i),
        .inport_accept_o(inport_accept_o),
        .inport_bvalid_o(inport_bvalid_o), .inport_bresp_o(inport_bresp_o),
        .inport_bid_o(inport_bid_o), .inport_bready_i(inport_bready_i),
        .inport_rvalid_o(inport_rvalid_o), .inport_rdata_o(inport_rdata_o),
        .inport_rresp_o(inport_rresp_o), .inport_rid_o(inport_rid_o),
        .inport_rlast_o(inport_rlast_o), .inport_rready_i(inport_rready_i),
        .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o),
        .outport_awid_o(outport_awid_o), .outport_awlen_o(outport_awlen_o),
        .outport_awburst_o(outport_awburst_o), .outport_awready_i(outport_awready_i),
        .outport_wvalid_o(outport_wvalid_o), .outport_wdata_o(outport_wdata_o),
        .outport_wstrb_o(outport_wstrb_o), .outport_wlast_o(outport_wlast_o),
        .outport_wready_i(outport_wready_i),
        .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i),
        .outport_bid_i(outport_bid_i), .outport_bready_o(outport_bready_o),
        .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o),
        .outport_arid_o(outport_arid_o), .outport_arlen_o(outport_arlen_o),
        .outport_arburst_o(outport_arburst_o), .outport_arready_i(outport_arready_i),
        .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
        .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
        .outport_rlast_i(outport_rlast_i), .outport_rready_o(outport_rready_o)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic [31:0] addr, input logic [3:0] id,
                             input logic [7:0] len, input logic [31:0] data);
        inport_valid_i = 1'b1; inport_write_i = 1'b1; inport_addr_i = addr;
        inport_id_i = id; inport_len_i = len; inport_burst_i = 2'b01;
        inport_wdata_i = data; inport_wstrb_i = 4'hF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inport_valid_i = 0; inport_write_i = 0; inport_addr_i = 0; inport_id_i = 0;
        inport_len_i = 0; inport_burst_i = 0; inport_wdata_i = 0; inport_wstrb_i = 0;
        inport_bready_i = 1; inport_rready_i = 1;
        outport_awready_i = 0; outport_wready_i = 0; outport_arready_i = 0;
        outport_bvalid_i = 0; outport_bresp_i = 0; outport_bid_i = 0;
        outport_rvalid_i = 0; outport_rdata_i = 0; outport_rresp_i = 0;
        outport_rid_i = 0; outport_rlast_i = 0;
`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
        err_clear_i = 0;
`endif
        repeat (3) step();
        #1;
        checks++; if (outport_awvalid_o !== 1'b0) $display("FAIL rst_awvalid: got %0h want 0", outport_awvalid_o); else passed++;
        checks++; if (outport_wvalid_o !== 1'b0) $display("FAIL rst_wvalid: got %0h want 0", outport_wvalid_o); else passed++;
        checks++; if (outport_arvalid_o !== 1'b0) $display("FAIL rst_arvalid: got %0h want 0", outport_arvalid_o); else passed++;
        checks++; if (outport_awaddr_o !== 32'h0) $display("FAIL rst_awaddr: got %0h want 0", outport_awaddr_o); else passed++;
        checks++; if (inport_accept_o !== 1'b0) $display("FAIL rst_accept: got %0h want 0", inport_accept_o); else passed++;
`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
        checks++; if (err_valid_o !== 1'b0) $display("FAIL rst_err_valid: got %0h want 0", err_valid_o); else passed++;
`endif
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        outport_awready_i = 1; outport_wready_i = 1;
        set_write(32'h1000, 4'h1, 8'd0, 32'hDEADBEEF);
        #1;
        checks++; if (inport_accept_o !== 1'b1) $display("FAIL sw_accept: got %0h want 1", inport_accept_o); else passed++;
        step();
        inport_valid_i = 0;
        #1;
        checks++; if (outport_awvalid_o !== 1'b1) $display("FAIL sw_awvalid: got %0h want 1", outport_awvalid_o); else passed++;
        checks++; if (outport_awaddr_o !== 32'h1000) $display("FAIL sw_awaddr: got %0h want 1000", outport_awaddr_o); else passed++;
        checks++; if (outport_awlen_o !== 8'd0) $display("FAIL sw_awlen: got %0h want 0", outport_awlen_o); else passed++;
        checks++; if (outport_wvalid_o !== 1'b1) $display("FAIL sw_wvalid: got %0h want 1", outport_wvalid_o); else passed++;
        checks++; if (outport_wdata_o !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %0h want deadbeef", outport_wdata_o); else passed++;
        checks++; if (outport_wstrb_o !== 4'hF) $display("FAIL sw_wstrb: got %0h want f", outport_wstrb_o); else passed++;
        checks++; if (outport_wlast_o !== 1'b1) $display("FAIL sw_wlast: got %0h want 1", outport_wlast_o); else passed++;
        step();
        #1;
        checks++; if (outport_awvalid_o !== 1'b0) $display("FAIL sw_aw_drop: got %0h want 0", outport_awvalid_o); else passed++;
        checks++; if (outport_wvalid_o !== 1'b0) $display("FAIL sw_w_drop: got %0h want 0", outport_wvalid_o); else passed++;
        checks++; if (dut.r_wr_out !== 4'd1) $display("FAIL sw_wr_out_busy: got %0d want 1", dut.r_wr_out); else passed++;
        outport_bvalid_i = 1; outport_bresp_i = 2'b00; outport_bid_i = 4'h1;
        #1;
        checks++; if (inport_bvalid_o !== 1'b1) $display("FAIL sw_bvalid_pass: got %0h want 1", inport_bvalid_o); else passed++;
        checks++; if (inport_bid_o !== 4'h1) $display("FAIL sw_bid_pass: got %0h want 1", inport_bid_o); else passed++;
        checks++; if (outport_bready_o !== 1'b1) $display("FAIL sw_bready_pass: got %0h want 1", outport_bready_o); else passed++;
        step();
        outport_bvalid_i = 0;
        #1;
        checks++; if (dut.r_wr_out !== 4'd0) $display("FAIL sw_wr_out_done: got %0d want 0", dut.r_wr_out); else passed++;
    endtask

    task automatic test_burst_write();
        outport_awready_i = 0; outport_wready_i = 1;
        set_write(32'h2000, 4'h2, 8'd3, 32'hA0);
        #1;
        checks++; if (inport_accept_o !== 1'b1) $display("FAIL bw_accept0: got %0h want 1", inport_accept_o); else passed++;
        for (int b = 1; b <= 4; b++) begin
            step();
            if (b < 4) inport_wdata_i = 32'hA0 + b; else inport_valid_i = 0;
            #1;
            if (b < 4) begin
                checks++; if (inport_accept_o !== 1'b1) $display("FAIL bw_accept%0d: got %0h want 1", b, inport_accept_o); else passed++;
            end
            checks++; if (outport_wvalid_o !== 1'b1 || outport_wdata_o !== 32'hA0 + b - 1) $display("FAIL bw_wbeat%0d: got v=%0h d=%0h want v=1 d=%0h", b, outport_wvalid_o, outport_wdata_o, 32'hA0 + b - 1); else passed++;
            checks++; if (outport_wlast_o !== (b == 4)) $display("FAIL bw_wlast%0d: got %0h want %0h", b, outport_wlast_o, (b == 4)); else passed++;
            checks++; if (outport_awvalid_o !== 1'b1) $display("FAIL bw_aw_wait%0d: got %0h want 1", b, outport_awvalid_o); else passed++;
        end
        step();
        step();
        outport_awready_i = 1;
        #1;
        checks++; if (outport_wvalid_o !== 1'b0) $display("FAIL bw_w_drained: got %0h want 0", outport_wvalid_o); else passed++;
        checks++; if (outport_awlen_o !== 8'd3 || outport_awid_o !== 4'h2) $display("FAIL bw_aw_fields: got len=%0h id=%0h want len=3 id=2", outport_awlen_o, outport_awid_o); else passed++;
        checks++; if (outport_awaddr_o !== 32'h2000) $display("FAIL bw_awaddr: got %0h want 2000", outport_awaddr_o); else passed++;
        step();
        #1;
        checks++; if (outport_awvalid_o !== 1'b0) $display("FAIL bw_aw_once: got %0h want 0", outport_awvalid_o); else passed++;
        outport_bvalid_i = 1; outport_bid_i = 4'h2;
        step();
        outport_bvalid_i = 0;
        #1;
        checks++; if (dut.r_wr_out !== 4'd0) $display("FAIL bw_wr_out: got %0d want 0", dut.r_wr_out); else passed++;
    endtask

    task automatic test_wbuf_full();
        int exp_acc [11] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        int beat = 0;
        int pops = 0;
        outport_awready_i = 1; outport_wready_i = 0;
        set_write(32'h5000, 4'h3, 8'd7, 32'h0);
        for (int cyc = 0; cyc < 24 && pops < 8; cyc++) begin
            outport_wready_i = (cyc >= 6);
            inport_valid_i = (beat < 8);
            inport_wdata_i = beat;
            #1;
            if (cyc < 11) begin
                checks++; if (inport_accept_o !== exp_acc[cyc][0]) $display("FAIL wf_accept_c%0d: got %0h want %0h", cyc, inport_accept_o, exp_acc[cyc][0]); else passed++;
            end
            if (outport_wvalid_o && outport_wready_i) begin
                checks++; if (outport_wdata_o !== pops || outport_wlast_o !== (pops == 7)) $display("FAIL wf_pop%0d: got d=%0h l=%0h want d=%0h l=%0h", pops, outport_wdata_o, outport_wlast_o, pops, (pops == 7)); else passed++;
                pops++;
            end
            if (inport_accept_o) beat++;
            step();
        end
        inport_valid_i = 0;
        checks++; if (beat != 8 || pops != 8) $display("FAIL wf_totals: got beats=%0d pops=%0d want 8/8", beat, pops); else passed++;
        outport_bvalid_i = 1; outport_bid_i = 4'h3;
        step();
        outport_bvalid_i = 0;
        #1;
        checks++; if (dut.r_wr_out !== 4'd0) $display("FAIL wf_wr_out: got %0d want 0", dut.r_wr_out); else passed++;
    endtask

    task automatic test_outstanding();
        outport_awready_i = 1; outport_wready_i = 1;
        for (int w = 0; w < 2; w++) begin
            set_write(32'h6000 + 32'(w * 16), 4'h4, 8'd0, 32'h60 + w);
            #1;
            checks++; if (inport_accept_o !== 1'b1) $display("FAIL os_accept%0d: got %0h want 1", w, inport_accept_o); else passed++;
            step();
            inport_valid_i = 0;
            step();
            step();
        end
        set_write(32'h6020, 4'h4, 8'd0, 32'h62);
        #1;
        checks++; if (inport_accept_o !== 1'b0) $display("FAIL os_stall_a: got %0h want 0", inport_accept_o); else passed++;
        step();
        #1;
        checks++; if (inport_accept_o !== 1'b0) $display("FAIL os_stall_b: got %0h want 0", inport_accept_o); else passed++;
        outport_bvalid_i = 1; outport_bid_i = 4'h4;
        #1;
        checks++; if (inport_accept_o !== 1'b0) $display("FAIL os_stall_bcycle: got %0h want 0", inport_accept_o); else passed++;
        step();
        outport_bvalid_i = 0;
        #1;
        checks++; if (inport_accept_o !== 1'b1) $display("FAIL os_release: got %0h want 1", inport_accept_o); else passed++;
        step();
        inport_valid_i = 0;
        step();
        outport_bvalid_i = 1;
        step();
        step();
        outport_bvalid_i = 0;
        #1;
        checks++; if (dut.r_wr_out !== 4'd0) $display("FAIL os_wr_out: got %0d want 0", dut.r_wr_out); else passed++;
    endtask

    task automatic test_read_interlock();
        outport_awready_i = 1; outport_wready_i = 1; outport_arready_i = 1;
        for (int c = 0; c < 7; c++) begin
            if (c == 0 || c == 1 || c == 3 || c == 5) begin
                set_write(32'h7000, 4'h5, 8'd3, 32'h70 + c);
            end else begin
                inport_valid_i = 1; inport_write_i = 0; inport_addr_i = 32'h8000;
                inport_id_i = 4'h6; inport_len_i = 8'd5; inport_burst_i = 2'b01;
            end
            #1;
            checks++; if (inport_accept_o !== (c != 2 && c != 4)) $display("FAIL ri_accept_c%0d: got %0h want %0h", c, inport_accept_o, (c != 2 && c != 4)); else passed++;
            if (c == 4) begin
                checks++; if (outport_arvalid_o !== 1'b0) $display("FAIL ri_no_ar: got %0h want 0", outport_arvalid_o); else passed++;
            end
            step();
        end
        inport_valid_i = 0;
        #1;
        checks++; if (outport_arvalid_o !== 1'b1) $display("FAIL ri_arvalid: got %0h want 1", outport_arvalid_o); else passed++;
        checks++; if (outport_araddr_o !== 32'h8000) $display("FAIL ri_araddr: got %0h want 8000", outport_araddr_o); else passed++;
        checks++; if (outport_arlen_o !== 8'd5 || outport_arid_o !== 4'h6) $display("FAIL ri_ar_fields: got len=%0h id=%0h want len=5 id=6", outport_arlen_o, outport_arid_o); else passed++;
        step();
        #1;
        checks++; if (outport_arvalid_o !== 1'b0) $display("FAIL ri_ar_drop: got %0h want 0", outport_arvalid_o); else passed++;
        for (int i = 0; i < 6; i++) begin
            outport_rvalid_i = 1; outport_rdata_i = 32'h100 + i; outport_rid_i = 4'h6;
            outport_rresp_i = 2'b00; outport_rlast_i = (i == 5);
            #1;
            if (i == 5) begin
                checks++; if (inport_rvalid_o !== 1'b1 || inport_rdata_o !== 32'h105 || inport_rlast_o !== 1'b1) $display("FAIL ri_r_pass: got v=%0h d=%0h l=%0h want v=1 d=105 l=1", inport_rvalid_o, inport_rdata_o, inport_rlast_o); else passed++;
                checks++; if (outport_rready_o !== 1'b1) $display("FAIL ri_rready: got %0h want 1", outport_rready_o); else passed++;
            end
            step();
        end
        outport_rvalid_i = 0; outport_rlast_i = 0;
        outport_bvalid_i = 1; outport_bid_i = 4'h5;
        step();
        outport_bvalid_i = 0;
        #1;
        checks++; if (dut.r_rd_out !== 4'd0) $display("FAIL ri_rd_out: got %0d want 0", dut.r_rd_out); else passed++;
        checks++; if (dut.r_wr_out !== 4'd0) $display("FAIL ri_wr_out: got %0d want 0", dut.r_wr_out); else passed++;
    endtask

`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
    task automatic test_err_capture();
        outport_awready_i = 1; outport_wready_i = 1;
        for (int k = 0; k < 2; k++) begin
            set_write(32'h9000, 4'h3, 8'd0, 32'h90);
            step();
            inport_valid_i = 0;
            step();
            step();
            outport_bvalid_i = 1; outport_bid_i = (k == 0) ? 4'h3 : 4'h5;
            outport_bresp_i = (k == 0) ? 2'b10 : 2'b11;
            step();
            outport_bvalid_i = 0; outport_bresp_i = 2'b00;
            #1;
            checks++; if (err_valid_o !== 1'b1 || err_resp_o !== 2'd2 || err_id_o !== 4'h3) $display("FAIL ec_capture%0d: got v=%0h r=%0h id=%0h want 1/2/3", k, err_valid_o, err_resp_o, err_id_o); else passed++;
        end
        err_clear_i = 1;
        step();
        err_clear_i = 0;
        #1;
        checks++; if (err_valid_o !== 1'b0) $display("FAIL ec_clear: got %0h want 0", err_valid_o); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_wbuf_full();
        test_outstanding();
        test_read_interlock();
`ifdef DCACHE_AXI_BRIDGE_ERR_CAPTURE_EN
        test_err_capture();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
